// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
// Rev 1.0
`default_nettype none

package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, inst} pairs with push/pop/flush and count.
// Rev 1.0
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t            mem_q [DEPTH];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    w_pop;

  assign w_pop   = pop_i && (count_q != '0);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_i, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so out_pc/out_inst read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush_i && push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: RV32I fetch PC, 1-cycle SRAM issue, fetch queue and redirect flush.
// Optional same-cycle response bypass when FETCH_BYPASS_EN is defined. Rev 1.0
`default_nettype none

module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic                    im_req,
  output logic [ADDR_W-1:0]       im_addr,
  input  logic [31:0]             im_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_inst,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          kill_q, kill_d;

  fetch_entry_t  w_head;
  fetch_entry_t  w_resp_entry;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_used;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;

  // Slots are reserved for reads in flight, so the queue can never overflow.
  assign w_used  = w_count + CW'(inflight_q);
  assign im_req  = rst && !redirect && (w_used < CW'(DEPTH));
  assign im_addr = fetch_pc_q[ADDR_W-1:0];

  assign w_resp       = inflight_q && !kill_q && !redirect;
  assign w_resp_entry = '{pc: inflight_pc_q, inst: im_rdata};
  assign occupancy    = w_count;

`ifdef FETCH_BYPASS_EN
  logic w_byp;
  assign w_byp     = w_resp && w_empty;
  assign out_valid = !w_empty || w_resp;
  assign out_pc    = w_byp ? inflight_pc_q : w_head.pc;
  assign out_inst  = w_byp ? im_rdata      : w_head.inst;
  assign w_push    = w_resp && !(w_byp && out_ready);
  assign w_pop     = !w_empty && out_ready;
`else
  assign out_valid = !w_empty;
  assign out_pc    = w_head.pc;
  assign out_inst  = w_head.inst;
  assign w_push    = w_resp;
  assign w_pop     = out_valid && out_ready;
`endif

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = im_req;
    inflight_pc_d = inflight_pc_q;
    kill_d        = redirect;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h0000_0003;
    end else if (im_req) begin
      fetch_pc_d    = fetch_pc_q + PC_STEP;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (w_push),
    .data_i  (w_resp_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .empty_o (w_empty),
    .count_o (w_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed checks of fetch_queue_unit against a behavioural SRAM.
// Rev 1.0
`default_nettype none

module tb_fetch_queue_unit;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [15:0] im_addr;
  logic [31:0] im_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  occupancy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .occupancy   (occupancy)
  );

  function automatic logic [31:0] word(input logic [15:0] a);
    return (a < 16'h000C) ? 32'h0000_0013 : {a, 16'h0013};
  endfunction

  always @(posedge clk) if (im_req) im_rdata <= word(im_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_occ(input int n);
    int k = 0;
    while (occupancy != 3'(n) && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("wait_occ", 32'(occupancy), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_im_req",  32'(im_req),    0);
    chk("rst_valid",   32'(out_valid), 0);
    chk("rst_occ",     32'(occupancy), 0);
    chk("rst_out_pc",  out_pc,         0);
    chk("rst_out_inst", out_inst,      0);

    // Start-up stream: one fetch and one output per cycle.
    rst = 1'b1; #1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) chk("start_addr", 32'(im_addr), 32'(4 * c));
      chk("start_valid", 32'(out_valid), 32'(c >= LAT));
      if (c >= LAT) chk("start_pc", out_pc, 32'(4 * (c - LAT)));
      if (c == LAT) chk("start_inst", out_inst, 32'h13);
      if (c < 4) begin @(negedge clk); #1; end
    end

    // Stall: queue saturates, fetch stops, head held.
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("stall_occ",   32'(occupancy), 4);
    chk("stall_req",   32'(im_req),    0);
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_pc",    out_pc,         32'(4 * (4 - LAT)));

    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_pc",    out_pc,         32'(4 * (4 - LAT) + 4 * j));
      if (j == 0) chk("drain_req0", 32'(im_req), 0);
      if (j == 1) begin
        chk("drain_req1",  32'(im_req),  1);
        chk("drain_addr1", 32'(im_addr), 32'(4 * (4 - LAT) + 16));
      end
      @(negedge clk); #1;
    end

    // Redirect with three queued entries and a read in flight.
    out_ready = 1'b0;
    wait_occ(3);
    redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("redir_req", 32'(im_req), 0);
    @(negedge clk);
    redirect = 1'b0; out_ready = 1'b1; #1;
    chk("redir_occ",   32'(occupancy), 0);
    chk("redir_valid", 32'(out_valid), 0);
    chk("redir_req1",  32'(im_req),    1);
    chk("redir_addr",  32'(im_addr),   32'h100);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk); #1;
      if (i < LAT - 1) chk("redir_gap", 32'(out_valid), 0);
    end
    chk("redir_valid2", 32'(out_valid), 1);
    chk("redir_pc",     out_pc,         32'h100);
    chk("redir_inst",   out_inst,       32'h0100_0013);
    @(negedge clk); #1;
    chk("redir_pc2", out_pc, 32'h104);

    // Back-to-back redirects: only the second target survives.
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect_pc = 32'h0000_0300;
    @(negedge clk);
    redirect = 1'b0; #1;
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk); #1;
      k++;
    end
    chk("b2b_lat", 32'(k), 32'(LAT));
    chk("b2b_pc",  out_pc, 32'h300);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0; #1;
    chk("wrap_addr0", 32'(im_addr), 32'hFFFC);
    @(negedge clk); #1;
    chk("wrap_addr1", 32'(im_addr), 32'h0000);
    repeat (LAT - 1) begin @(negedge clk); #1; end
    chk("wrap_pc0",   out_pc,   32'hFFFF_FFFC);
    chk("wrap_inst0", out_inst, 32'hFFFC_0013);
    @(negedge clk); #1;
    chk("wrap_pc1",   out_pc,   32'h0000_0000);
    chk("wrap_inst1", out_inst, 32'h0000_0013);
    @(negedge clk); #1;
    chk("wrap_pc2",   out_pc,   32'h0000_0004);

    // Asynchronous reset mid-stream clears everything immediately.
    out_ready = 1'b0;
    wait_occ(2);
    #2;
    rst = 1'b0; #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_occ",   32'(occupancy), 0);
    chk("mrst_req",   32'(im_req),    0);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; #1;
    chk("mrst_req1",  32'(im_req),  1);
    chk("mrst_addr",  32'(im_addr), 0);
    repeat (LAT) begin @(negedge clk); #1; end
    chk("mrst_valid2", 32'(out_valid), 1);
    chk("mrst_pc",     out_pc,         0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
